mux_rr_scheduler: RTL and testbench

- Round-robin scheduler that owns the 3-bit select of the shared 8:1 bit mux in the combinational datapath.
- Up to 8 requesters compete for the mux path. The scheduler grants one at a time and drives the mux select with the winner's index.
- A grant is held for a bounded burst of acknowledged beats, then passed on fairly.
- Sits between requester logic and the 8:1 mux; the downstream consumer pulses ack per transferred beat.

---
 rtl/mux_rr_scheduler_if.sv | 24 ++
 rtl/mux_rr_scheduler.sv | 118 +++++++++++
 tb/tb_mux_rr_scheduler.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/mux_rr_scheduler_if.sv
// Handshake bundle between requesters/consumer and the mux scheduler.
// master: drives req/ack; slave: scheduler, drives sel/grant/busy/beat_cnt.
interface mux_rr_scheduler_if #(
    parameter int N_REQ  = 8,
    parameter int SEL_W  = 3,
    parameter int BCNT_W = 4
);
    logic [N_REQ-1:0]  req;
    logic              ack;
    logic [SEL_W-1:0]  sel;
    logic [N_REQ-1:0]  grant;
    logic              busy;
    logic [BCNT_W-1:0] beat_cnt;

    modport master (
        output req, ack,
        input  sel, grant, busy, beat_cnt
    );

    modport slave (
        input  req, ack,
        output sel, grant, busy, beat_cnt
    );
endinterface

// File: rtl/mux_rr_scheduler.sv
// Round-robin owner of the 8:1 mux select; bursts of up to MAX_BURST acked beats.
// Ports: clk, rst_n (sync, active-low), bus (slave modport: req, ack in;
// sel, grant, busy, beat_cnt out, all registered).
// Optional: define MUX_SCHED_PRIO0_EN to give req[0] strict priority at every
// arbitration point without disturbing round-robin order among 1..N_REQ-1.
module mux_rr_scheduler #(
    parameter int N_REQ     = 8,
    parameter int SEL_W     = 3,
    parameter int MAX_BURST = 4,
    parameter int BCNT_W    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    mux_rr_scheduler_if.slave  bus
);
    localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(MAX_BURST - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t            state;
    logic [SEL_W-1:0]  sel_q;
    logic [SEL_W-1:0]  last_ptr;
    logic [N_REQ-1:0]  grant_q;
    logic              busy_q;
    logic [BCNT_W-1:0] cnt_q;

    logic              release_ev;
    logic [SEL_W-1:0]  base;
    logic [SEL_W-1:0]  idx;
    logic              found;
    logic [SEL_W-1:0]  win;

    assign bus.sel      = sel_q;
    assign bus.grant    = grant_q;
    assign bus.busy     = busy_q;
    assign bus.beat_cnt = cnt_q;

    always_comb begin
        release_ev = 1'b0;
        base       = last_ptr;
        idx        = '0;
        found      = 1'b0;
        win        = '0;

        if (state == GRANT) begin
            release_ev = !bus.req[sel_q] ||
                         (bus.ack && (cnt_q == LAST_BEAT));
            base = sel_q;
`ifdef MUX_SCHED_PRIO0_EN
            // A grant to requester 0 leaves the rotation pointer alone.
            if (sel_q == '0)
                base = last_ptr;
`endif
        end

        // Descending scan so the lowest offset from base+1 wins;
        // offset N_REQ wraps to base itself, i.e. the holder is searched last.
        for (int i = N_REQ; i >= 1; i--) begin
            idx = base + SEL_W'(i);
            if (bus.req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end

`ifdef MUX_SCHED_PRIO0_EN
        if (bus.req[0]) begin
            found = 1'b1;
            win   = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            sel_q    <= '0;
            grant_q  <= '0;
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            last_ptr <= SEL_W'(N_REQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state   <= GRANT;
                        sel_q   <= win;
                        grant_q <= N_REQ'(1) << win;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                GRANT: begin
                    if (release_ev) begin
                        last_ptr <= base;
                        cnt_q    <= '0;
                        if (found) begin
                            sel_q   <= win;
                            grant_q <= N_REQ'(1) << win;
                        end else begin
                            state   <= IDLE;
                            grant_q <= '0;
                            busy_q  <= 1'b0;
                        end
                    end else if (bus.ack) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Directed, table-driven bench for mux_rr_scheduler.
// Covers reset, bursts, early release, wrap, mid-burst reset, fairness.
module tb_mux_rr_scheduler;
    logic clk;
    logic rst_n;

    mux_rr_scheduler_if #(.N_REQ(8), .SEL_W(3), .BCNT_W(4)) bus ();

    mux_rr_scheduler #(
        .N_REQ(8), .SEL_W(3), .MAX_BURST(4), .BCNT_W(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic [7:0] req;
        logic       ack;
        logic [2:0] sel;
        logic [7:0] grant;
        logic       busy;
        logic [3:0] cnt;
    } vec_t;

    vec_t vecs[$];
    int errors = 0;
    int checks = 0;

    task automatic add(input logic r, input logic [7:0] q, input logic a,
                       input logic [2:0] s, input logic [7:0] g,
                       input logic b, input logic [3:0] c);
        vec_t v;
        v.rst_n = r; v.req = q; v.ack = a;
        v.sel = s; v.grant = g; v.busy = b; v.cnt = c;
        vecs.push_back(v);
    endtask

    task automatic step(input vec_t v, input string tag, input int id);
        rst_n   = v.rst_n;
        bus.req = v.req;
        bus.ack = v.ack;
        @(posedge clk);
        #1;
        checks++;
        if ({bus.sel, bus.grant, bus.busy, bus.beat_cnt} !==
            {v.sel, v.grant, v.busy, v.cnt}) begin
            errors++;
            $display("FAIL %s[%0d]: got sel=%0d grant=%h busy=%b cnt=%0d, want sel=%0d grant=%h busy=%b cnt=%0d",
                     tag, id, bus.sel, bus.grant, bus.busy, bus.beat_cnt,
                     v.sel, v.grant, v.busy, v.cnt);
        end
    endtask

    initial begin
        vec_t v;
        int order [9];

        rst_n   = 1'b0;
        bus.req = '0;
        bus.ack = 1'b0;

        // reset, then idle for 5 cycles (last one with a stray ack)
        add(0, 8'h00, 0, 0, 8'h00, 0, 0);
        add(0, 8'h00, 0, 0, 8'h00, 0, 0);
        add(1, 8'h00, 0, 0, 8'h00, 0, 0);
        add(1, 8'h00, 0, 0, 8'h00, 0, 0);
        add(1, 8'h00, 0, 0, 8'h00, 0, 0);
        add(1, 8'h00, 0, 0, 8'h00, 0, 0);
        add(1, 8'h00, 1, 0, 8'h00, 0, 0);
        // lone requester 0, continuous ack, regrant after the 4th beat
        add(1, 8'h01, 1, 0, 8'h01, 1, 0);
        add(1, 8'h01, 1, 0, 8'h01, 1, 1);
        add(1, 8'h01, 1, 0, 8'h01, 1, 2);
        add(1, 8'h01, 1, 0, 8'h01, 1, 3);
        add(1, 8'h01, 1, 0, 8'h01, 1, 0);
        add(1, 8'h00, 0, 0, 8'h00, 0, 0);
        // req=86: 1,2,7,1 back-to-back, wrap 7->1
        add(1, 8'h86, 1, 1, 8'h02, 1, 0);
        add(1, 8'h86, 1, 1, 8'h02, 1, 1);
        add(1, 8'h86, 1, 1, 8'h02, 1, 2);
        add(1, 8'h86, 1, 1, 8'h02, 1, 3);
        add(1, 8'h86, 1, 2, 8'h04, 1, 0);
        add(1, 8'h86, 1, 2, 8'h04, 1, 1);
        add(1, 8'h86, 1, 2, 8'h04, 1, 2);
        add(1, 8'h86, 1, 2, 8'h04, 1, 3);
        add(1, 8'h86, 1, 7, 8'h80, 1, 0);
        add(1, 8'h86, 1, 7, 8'h80, 1, 1);
        add(1, 8'h86, 1, 7, 8'h80, 1, 2);
        add(1, 8'h86, 1, 7, 8'h80, 1, 3);
        add(1, 8'h86, 1, 1, 8'h02, 1, 0);
        add(1, 8'h00, 0, 1, 8'h00, 0, 0);
        // req=28: holder 3 drops after 2 acks -> 5
        add(1, 8'h28, 1, 3, 8'h08, 1, 0);
        add(1, 8'h28, 1, 3, 8'h08, 1, 1);
        add(1, 8'h28, 1, 3, 8'h08, 1, 2);
        add(1, 8'h20, 0, 5, 8'h20, 1, 0);
        // mid-burst reset, regrant one cycle after release of reset
        add(1, 8'h20, 1, 5, 8'h20, 1, 1);
        add(1, 8'h20, 1, 5, 8'h20, 1, 2);
        add(0, 8'h20, 1, 0, 8'h00, 0, 0);
        add(1, 8'h20, 0, 5, 8'h20, 1, 0);
        add(1, 8'h00, 0, 5, 8'h00, 0, 0);
        // holder 4 with req0 pending: no preemption, then release
        add(1, 8'h10, 0, 4, 8'h10, 1, 0);
        add(1, 8'h31, 1, 4, 8'h10, 1, 1);
        add(1, 8'h31, 1, 4, 8'h10, 1, 2);
        add(1, 8'h31, 1, 4, 8'h10, 1, 3);
`ifdef MUX_SCHED_PRIO0_EN
        add(1, 8'h31, 1, 0, 8'h01, 1, 0);
        add(1, 8'h31, 0, 0, 8'h01, 1, 0);
`else
        add(1, 8'h31, 1, 5, 8'h20, 1, 0);
        add(1, 8'h31, 0, 5, 8'h20, 1, 0);
`endif
        add(1, 8'h30, 0, 5, 8'h20, 1, 0);
        add(1, 8'h00, 0, 5, 8'h00, 0, 0);

        for (int i = 0; i < vecs.size(); i++)
            step(vecs[i], "vec", i);

        // all lines requesting, continuous ack: rotation from last_ptr=5
`ifdef MUX_SCHED_PRIO0_EN
        order = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
`else
        order = '{6, 7, 0, 1, 2, 3, 4, 5, 6};
`endif
        for (int g = 0; g < 9; g++) begin
            for (int b = 0; b < 4; b++) begin
                v.rst_n = 1'b1;
                v.req   = 8'hFF;
                v.ack   = 1'b1;
                v.sel   = 3'(order[g]);
                v.grant = 8'h01 << order[g];
                v.busy  = 1'b1;
                v.cnt   = 4'(b);
                step(v, "fair", g * 4 + b);
            end
        end
        v.rst_n = 1'b1;
        v.req   = 8'h00;
        v.ack   = 1'b0;
        v.sel   = 3'(order[8]);
        v.grant = 8'h00;
        v.busy  = 1'b0;
        v.cnt   = 4'd0;
        step(v, "fair_end", 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
